// File: rtl/sram_port_arbiter_pkg.sv
// Shared video package for the SRAM port arbiter.
// It holds the arbiter state enum, the idle strobe constant and the
// default address/data widths.
package sram_port_arbiter_pkg;
  localparam int AW_DEF = 20;
  localparam int DW_DEF = 16;

  // {ce, oe, we}: all strobes are active-low, so all ones means the chip is idle
  localparam logic [2:0] STROBE_IDLE = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } arb_state_e;
endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the SRAM pads.
//   slave  : the arbiter. It receives the requests and pad data, and drives
//            the acks, read data and SRAM pins.
//   master : the requesters and pads.
interface sram_port_arbiter_if
  import sram_port_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) ();
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d_out;
  logic          sram_d_oe;
  logic [DW-1:0] sram_d_in;
  logic          sram_ce;
  logic          sram_oe;
  logic          sram_we;
  logic          busy;

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, sram_d_in,
    output wr_ack, rd_ack, rd_data, rd_valid, sram_a, sram_d_out,
           sram_d_oe, sram_ce, sram_oe, sram_we, busy
  );

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, sram_d_in,
    input  wr_ack, rd_ack, rd_data, rd_valid, sram_a, sram_d_out,
           sram_d_oe, sram_ce, sram_oe, sram_we, busy
  );
endinterface

// File: rtl/sram_port_arbiter_phase.sv
// sram_phase_counter: a loadable down-counter that times one access phase.
//   clk, rst : clock and synchronous active-low reset
//   load     : load load_val; this takes priority over dec
//   dec      : count down by one; the count stops at zero
//   tc       : terminal count, meaning this is the last cycle of the phase
module sram_phase_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_val,
  output logic          tc
);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst)                     cnt <= '0;
    else if (load)                cnt <= load_val;
    else if (dec && cnt != '0)    cnt <= cnt - CW'(1);
  end

  // "<= 1" rather than "== 1", so a zero count can never stall the FSM
  assign tc = (cnt <= CW'(1));
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one async SRAM between the capture writer and the
// display reader. Reads have fixed priority. A write that has waited
// STARVE_MAX read grants is forced through next.
//   clk, rst : clock and synchronous active-low reset
//   en       : grant enable; an access already in flight always completes
//   bus      : requester handshakes and SRAM pins (slave side)
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int RD_CYCLES  = 2,
  parameter int WR_CYCLES  = 3,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  sram_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int CW = 8;

  arb_state_e    state_q, state_d;
  logic          grant_rd, grant_wr, ld, dec, tc, starved;
  logic [CW-1:0] ld_val;
  logic [SW-1:0] streak;
  logic [AW-1:0] a_q;
  logic [DW-1:0] d_q, rd_data_q;
  logic          wr_ack_q, rd_ack_q, rd_valid_q;
  logic          ce, oe, we, d_oe;

  assign starved = (streak == SW'(STARVE_MAX));

  sram_phase_counter #(.CW(CW)) u_phase (
    .clk(clk), .rst(rst), .load(ld), .dec(dec), .load_val(ld_val), .tc(tc)
  );

  always_comb begin
    state_d  = state_q;
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    ld       = 1'b0;
    dec      = 1'b0;
    ld_val   = CW'(RD_CYCLES);
    case (state_q)
      IDLE: if (en) begin
        if (bus.wr_req && starved) grant_wr = 1'b1;
        else if (bus.rd_req)       grant_rd = 1'b1;
        else if (bus.wr_req)       grant_wr = 1'b1;
        if (grant_rd) begin
          state_d = RD;
          ld      = 1'b1;
        end else if (grant_wr) begin
          state_d = WR_SETUP;
        end
      end
      RD:       if (tc) state_d = IDLE; else dec = 1'b1;
      WR_SETUP: begin
        state_d = WR_PULSE;
        ld      = 1'b1;
        ld_val  = CW'(WR_CYCLES);
      end
      WR_PULSE: if (tc) state_d = WR_HOLD; else dec = 1'b1;
      WR_HOLD:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // The strobes decode directly from the registered state, so they switch on
  // the same edge as the state and are forced idle by reset.
  always_comb begin
    {ce, oe, we} = STROBE_IDLE;
    d_oe         = 1'b0;
    case (state_q)
      RD:                begin ce = 1'b0; oe = 1'b0; end
      WR_SETUP, WR_HOLD: begin ce = 1'b0; d_oe = 1'b1; end
      WR_PULSE:          begin ce = 1'b0; we = 1'b0; d_oe = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_ack_q   <= 1'b0;
      rd_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      a_q        <= '0;
      d_q        <= '0;
      streak     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ack_q   <= grant_wr;
      rd_ack_q   <= grant_rd;
      rd_valid_q <= (state_q == RD) && tc;
      // Pad data is captured at the edge that ends the last read cycle.
      if ((state_q == RD) && tc) rd_data_q <= bus.sram_d_in;
      if (grant_rd) a_q <= bus.rd_addr;
      if (grant_wr) begin
        a_q <= bus.wr_addr;
        d_q <= bus.wr_data;
      end
      if (grant_wr || (state_q == IDLE && !bus.wr_req)) streak <= '0;
      else if (grant_rd && bus.wr_req && !starved)      streak <= streak + SW'(1);
    end
  end

  assign bus.wr_ack     = wr_ack_q;
  assign bus.rd_ack     = rd_ack_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.sram_a     = a_q;
  assign bus.sram_d_out = d_q;
  assign bus.sram_d_oe  = d_oe;
  assign bus.sram_ce    = ce;
  assign bus.sram_oe    = oe;
  assign bus.sram_we    = we;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter. A timeline model of the
// specification is compared with every DUT output on every cycle. The
// directed scenarios also carry literal expectations.
module tb_sram_port_arbiter;
  localparam int AW = 20, DW = 16, RDC = 2, WRC = 3, SMAX = 4;

  logic clk = 1'b0, rst = 1'b0, en = 1'b0;
  int   n_chk = 0, n_fail = 0, cyc = 0;

  sram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  sram_port_arbiter #(.AW(AW), .DW(DW), .RD_CYCLES(RDC), .WR_CYCLES(WRC),
                      .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .en(en), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    if (a == 20'h12345) return 16'hBEEF;
    return a[15:0] ^ 16'hC3C3;
  endfunction

  assign bus.sram_d_in = mem_f(bus.sram_a);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_str(input string nm, input string act, input string exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %s expected %s", nm, act, exp);
    end
  endtask

  // Model: an access is a kind (1 = read, 2 = write) plus the cycle number t
  // since its grant edge. Cycle t=1 is the first cycle after the grant.
  int            m_kind = 0, m_t = 0, m_streak = 0;
  logic [AW-1:0] m_a = '0;
  logic [DW-1:0] m_d = '0, m_rdd = '0;
  bit            m_wr_ack = 0, m_rd_ack = 0, m_vld = 0;
  bit            go_w, go_r;

  function automatic int acc_len(input int k);
    return (k == 1) ? RDC : WRC + 2;
  endfunction

  always @(posedge clk) begin
    cyc++;
    m_wr_ack = 0; m_rd_ack = 0; m_vld = 0;
    if (!rst) begin
      m_kind = 0; m_t = 0; m_streak = 0; m_a = '0; m_d = '0; m_rdd = '0;
    end else if (m_kind != 0) begin
      if (m_t == acc_len(m_kind)) begin
        if (m_kind == 1) begin m_vld = 1; m_rdd = mem_f(m_a); end
        m_kind = 0; m_t = 0;
      end else m_t++;
    end else begin
      go_w = en && bus.wr_req && (m_streak == SMAX || !bus.rd_req);
      go_r = en && bus.rd_req && !go_w;
      if (go_w) begin
        m_kind = 2; m_t = 1; m_wr_ack = 1; m_a = bus.wr_addr; m_d = bus.wr_data;
        m_streak = 0;
      end else begin
        if (!bus.wr_req) m_streak = 0;
        else if (go_r && m_streak < SMAX) m_streak++;
        if (go_r) begin m_kind = 1; m_t = 1; m_rd_ack = 1; m_a = bus.rd_addr; end
      end
    end
  end

  always @(negedge clk) if (cyc > 0) begin
    check("ce",       bus.sram_ce,    m_kind == 0);
    check("oe",       bus.sram_oe,    m_kind != 1);
    check("we",       bus.sram_we,    !(m_kind == 2 && m_t >= 2 && m_t <= WRC + 1));
    check("d_oe",     bus.sram_d_oe,  m_kind == 2);
    check("busy",     bus.busy,       m_kind != 0);
    check("wr_ack",   bus.wr_ack,     m_wr_ack);
    check("rd_ack",   bus.rd_ack,     m_rd_ack);
    check("rd_valid", bus.rd_valid,   m_vld);
    check("rd_data",  bus.rd_data,    m_rdd);
    check("sram_a",   bus.sram_a,     m_a);
    check("d_out",    bus.sram_d_out, m_d);
  end

  task automatic wait_ack(input bit wr, input string nm);
    int n = 0;
    while (!(wr ? bus.wr_ack : bus.rd_ack) && n < 40) begin @(negedge clk); n++; end
    check({nm, "_timeout"}, n < 40, 1);
  endtask

  task automatic collect(input int want, output string seq);
    seq = "";
    for (int i = 0; i < 80 && seq.len() < want; i++) begin
      @(negedge clk);
      if (bus.rd_ack) seq = {seq, "R"};
      if (bus.wr_ack) seq = {seq, "W"};
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int    cnt_a, cnt_b, voff, n;
    logic  [31:0] v0, v1, v2, v3;
    string seq;
    bus.wr_req = 0; bus.rd_req = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_ce", bus.sram_ce, 1);
    check("rst_we", bus.sram_we, 1);
    check("rst_doe", bus.sram_d_oe, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rdata", bus.rd_data, 0);
    check("rst_addr", bus.sram_a, 0);
    rst = 1; en = 1;
    repeat (2) @(negedge clk);

    // Single read
    bus.rd_addr = 20'h12345; bus.rd_req = 1;
    wait_ack(0, "rd1");
    bus.rd_req = 0; bus.rd_addr = '0;
    cnt_a = 0; voff = -1; v0 = 0; v1 = 0;
    for (int i = 0; i < 6; i++) begin
      if (!bus.sram_oe) cnt_a++;
      if (bus.rd_valid) begin voff = i; v0 = bus.rd_data; v1 = bus.sram_ce; end
      @(negedge clk);
    end
    check("rd_oe_cycles", cnt_a, 2);
    check("rd_valid_offset", voff, 2);
    check("rd_data_beef", v0, 16'hBEEF);
    check("rd_valid_ce_idle", v1, 1);
    check("rd_data_hold", bus.rd_data, 16'hBEEF);

    // Single write; requester inputs change right after the ack
    bus.wr_addr = 20'h00010; bus.wr_data = 16'hA5A5; bus.wr_req = 1;
    wait_ack(1, "wr1");
    bus.wr_req = 0; bus.wr_addr = '1; bus.wr_data = '0;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 8; i++) begin
      if (!bus.sram_we) cnt_a++;
      if (bus.sram_d_oe) cnt_b++;
      if (i == 0) v0 = bus.sram_we;
      if (i == 4) begin v1 = {bus.sram_we, bus.sram_d_oe}; v2 = bus.sram_a; v3 = bus.sram_d_out; end
      @(negedge clk);
    end
    check("wr_we_cycles", cnt_a, 3);
    check("wr_doe_cycles", cnt_b, 5);
    check("wr_setup_we", v0, 1);
    check("wr_hold_we_doe", v1, 2'b11);
    check("wr_hold_addr", v2, 20'h00010);
    check("wr_hold_data", v3, 16'hA5A5);

    // Both requests held: starvation guard
    bus.rd_addr = 20'h00100; bus.wr_addr = 20'h00200; bus.wr_data = 16'h1234;
    bus.rd_req = 1; bus.wr_req = 1;
    collect(10, seq);
    bus.rd_req = 0; bus.wr_req = 0;
    check_str("grant_order", seq, "RRRRWRRRRW");
    repeat (8) @(negedge clk);

    // Simultaneous requests with streak 0: read first, write after read + idle
    bus.rd_addr = 20'h00400; bus.wr_addr = 20'h00500; bus.wr_data = 16'h0F0F;
    bus.rd_req = 1; bus.wr_req = 1;
    n = 0;
    while (!(bus.rd_ack || bus.wr_ack) && n < 40) begin @(negedge clk); n++; end
    check("sim_first_is_read", {bus.rd_ack, bus.wr_ack}, 2'b10);
    bus.rd_req = 0;
    n = 0;
    while (!bus.wr_ack && n < 40) begin @(negedge clk); n++; end
    check("sim_wr_ack_gap", n, 3);
    bus.wr_req = 0;
    repeat (8) @(negedge clk);

    // Reset during WR_PULSE
    bus.wr_addr = 20'h00333; bus.wr_data = 16'h5555; bus.wr_req = 1;
    wait_ack(1, "wr_rst");
    @(negedge clk);
    check("pre_rst_we_low", bus.sram_we, 0);
    rst = 0; bus.wr_req = 0;
    @(negedge clk);
    check("rst_mid_we", bus.sram_we, 1);
    check("rst_mid_doe", bus.sram_d_oe, 0);
    check("rst_mid_busy", bus.busy, 0);
    rst = 1;
    cnt_a = 0;
    repeat (8) begin @(negedge clk); if (bus.wr_ack) cnt_a++; end
    check("no_wr_reack", cnt_a, 0);

    // Reset mid-read clears the streak
    bus.rd_addr = 20'h00600; bus.wr_addr = 20'h00700; bus.wr_data = 16'h7777;
    bus.rd_req = 1; bus.wr_req = 1;
    collect(2, seq);
    check_str("pre_rst_grants", seq, "RR");
    rst = 0;
    @(negedge clk);
    rst = 1;
    collect(5, seq);
    bus.rd_req = 0; bus.wr_req = 0;
    check_str("streak_cleared_by_rst", seq, "RRRRW");
    repeat (10) @(negedge clk);

    // en low: no grants, strobes idle; grant follows en rising
    en = 0; bus.rd_req = 1; bus.wr_req = 1;
    cnt_a = 0; cnt_b = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rd_ack || bus.wr_ack) cnt_a++;
      if (!bus.sram_ce) cnt_b++;
    end
    check("en0_no_ack", cnt_a, 0);
    check("en0_ce_idle", cnt_b, 0);
    en = 1;
    @(negedge clk);
    check("en_rise_grant", bus.rd_ack, 1);
    bus.rd_req = 0; bus.wr_req = 0;
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
